multicycle_ctrl: RTL and testbench



---
 rtl/multicycle_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RISC-V core.
// A single shared datapath (register file, ALU, immediate unit and unified
// instruction/data memory) is stepped through fetch, decode, execute, memory
// and writeback. This module drives every mux select and write enable,
// stalls on memory handshakes, counts retired instructions and halts on an
// unsupported opcode.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   op              instr[6:0] from the instruction register
//   flag            ALU branch-condition result (used only in BRANCH)
//   mem_ready       memory access completes this cycle
//   PCWrite/IRWrite PC and IR/oldPC enables
//   AdrSrc          memory address: 0 = PC, 1 = ALUout
//   ALUsrcA/B       ALU operand selects
//   ALUop           00 add, 01 branch compare, 10 funct-decoded
//   ResultSrc       00 ALUout, 01 memory data, 10 ALU direct, 11 IMM
//   RegWrite        register file write enable
//   RamWrite        memory write enable
//   IMMsrc          immediate format: 000 I, 001 S, 010 B, 011 U, 100 J
//   halted          sticky illegal-opcode indicator
//   instret         retired-instruction count (wraps)
//   state           current state encoding for debug
//
// state    | meaning
// ---------+---------------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC+4 when memory ready
// DECODE   | ALUout <= oldPC + B-immediate (branch target precompute)
// MEMADR   | ALUout <= rs1 + I/S immediate
// MEMREAD  | load data from ALUout address, wait for memory
// MEMWB    | rd <= memory data register
// MEMWRITE | store to ALUout address, held until memory ready
// EXECR    | R-type ALU operation
// EXECI    | I-type ALU operation
// ALUWB    | rd <= ALUout
// BRANCH   | compare rs1/rs2, PC <= precomputed target when flag
// JAL      | PC <= precomputed target, ALU forms oldPC+4
// JALR     | PC <= rs1 + imm
// LINKWB   | rd <= oldPC + 4
// LUI      | rd <= U-immediate
// ILLEGAL  | unsupported opcode, parked until reset

module multicycle_ctrl #(
    parameter int WD = 32,
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [6:0]    op,
    input  logic          flag,
    input  logic          mem_ready,
    output logic          PCWrite,
    output logic          IRWrite,
    output logic          AdrSrc,
    output logic [1:0]    ALUsrcA,
    output logic [1:0]    ALUsrcB,
    output logic [1:0]    ALUop,
    output logic [1:0]    ResultSrc,
    output logic          RegWrite,
    output logic          RamWrite,
    output logic [2:0]    IMMsrc,
    output logic          halted,
    output logic [WD-1:0] instret,
    output logic [SW-1:0] state
);

    localparam logic [SW-1:0] S_FETCH    = SW'(0);
    localparam logic [SW-1:0] S_DECODE   = SW'(1);
    localparam logic [SW-1:0] S_MEMADR   = SW'(2);
    localparam logic [SW-1:0] S_MEMREAD  = SW'(3);
    localparam logic [SW-1:0] S_MEMWB    = SW'(4);
    localparam logic [SW-1:0] S_MEMWRITE = SW'(5);
    localparam logic [SW-1:0] S_EXECR    = SW'(6);
    localparam logic [SW-1:0] S_EXECI    = SW'(7);
    localparam logic [SW-1:0] S_ALUWB    = SW'(8);
    localparam logic [SW-1:0] S_BRANCH   = SW'(9);
    localparam logic [SW-1:0] S_JAL      = SW'(10);
    localparam logic [SW-1:0] S_JALR     = SW'(11);
    localparam logic [SW-1:0] S_LINKWB   = SW'(12);
    localparam logic [SW-1:0] S_LUI      = SW'(13);
    localparam logic [SW-1:0] S_ILLEGAL  = SW'(14);

    logic [SW-1:0] state_q, state_d;
    logic [WD-1:0] instret_q, instret_d;

    // State register and retired-instruction counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    7'b0000011,
                    7'b0100011: state_d = S_MEMADR;
                    7'b0110011: state_d = S_EXECR;
                    7'b0010011: state_d = S_EXECI;
                    7'b1100011: state_d = S_BRANCH;
                    7'b1101111: state_d = S_JAL;
                    7'b1100111: state_d = S_JALR;
                    7'b0110111: state_d = S_LUI;
                    default:    state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_JALR:     state_d = S_LINKWB;
            S_LINKWB:   state_d = S_FETCH;
            S_LUI:      state_d = S_FETCH;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_FETCH;
        endcase
    end

    // An instruction retires on any entry into FETCH from another state;
    // FETCH stalls and ILLEGAL never satisfy this.
    always_comb begin
        instret_d = instret_q;
        if ((state_d == S_FETCH) && (state_q != S_FETCH))
            instret_d = instret_q + WD'(1);
    end

    // Output decode
    always_comb begin
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUsrcA   = 2'b00;
        ALUsrcB   = 2'b00;
        ALUop     = 2'b00;
        ResultSrc = 2'b00;
        RegWrite  = 1'b0;
        RamWrite  = 1'b0;
        IMMsrc    = 3'b000;
        halted    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUsrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                ALUsrcA = 2'b10;
                ALUsrcB = 2'b01;
                IMMsrc  = 3'b010;
            end
            S_MEMADR: begin
                ALUsrcA = 2'b01;
                ALUsrcB = 2'b01;
                IMMsrc  = op[5] ? 3'b001 : 3'b000;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                RamWrite = 1'b1;
            end
            S_EXECR: begin
                ALUsrcA = 2'b01;
                ALUop   = 2'b10;
            end
            S_EXECI: begin
                ALUsrcA = 2'b01;
                ALUsrcB = 2'b01;
                ALUop   = 2'b10;
            end
            S_ALUWB:    RegWrite = 1'b1;
            S_BRANCH: begin
                ALUsrcA = 2'b01;
                ALUop   = 2'b01;
                PCWrite = flag;
            end
            S_JAL: begin
                ALUsrcA = 2'b10;
                ALUsrcB = 2'b10;
                PCWrite = 1'b1;
            end
            S_JALR: begin
                ALUsrcA   = 2'b01;
                ALUsrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
            end
            S_LINKWB: begin
                ALUsrcA   = 2'b10;
                ALUsrcB   = 2'b10;
                ResultSrc = 2'b10;
                RegWrite  = 1'b1;
            end
            S_LUI: begin
                ALUsrcB   = 2'b01;
                IMMsrc    = 3'b011;
                ResultSrc = 2'b11;
                RegWrite  = 1'b1;
            end
            S_ILLEGAL:  halted = 1'b1;
            default: ;
        endcase
    end

    assign instret = instret_q;
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    localparam int WD = 4;
    localparam int SW = 4;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_L  = 7'b0000011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_J  = 7'b1101111;
    localparam logic [6:0] OP_JR = 7'b1100111;
    localparam logic [6:0] OP_U  = 7'b0110111;
    localparam logic [6:0] OP_X  = 7'b1111111;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    op;
    logic          flag;
    logic          mem_ready;
    logic          PCWrite, IRWrite, AdrSrc, RegWrite, RamWrite, halted;
    logic [1:0]    ALUsrcA, ALUsrcB, ALUop, ResultSrc;
    logic [2:0]    IMMsrc;
    logic [WD-1:0] instret;
    logic [SW-1:0] state;

    multicycle_ctrl #(.WD(WD), .SW(SW)) dut (
        .clk(clk), .rst(rst), .op(op), .flag(flag), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
        .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .ALUop(ALUop),
        .ResultSrc(ResultSrc), .RegWrite(RegWrite), .RamWrite(RamWrite),
        .IMMsrc(IMMsrc), .halted(halted), .instret(instret), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [3:0]  st;
        logic [16:0] ctrl;
        logic [3:0]  ir;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   n_push = 0;
    event chk_now;

    logic [16:0] act_ctrl;
    assign act_ctrl = {PCWrite, IRWrite, AdrSrc, ALUsrcA, ALUsrcB, ALUop,
                       ResultSrc, RegWrite, RamWrite, IMMsrc, halted};

    // Expected control word per state, straight from the state table.
    function automatic logic [16:0] exp_ctrl(int st, bit mr, bit fl, logic [6:0] o);
        logic pcw, irw, adr, rw, ramw, hlt;
        logic [1:0] a, b, aop, res;
        logic [2:0] imm;
        pcw = 0; irw = 0; adr = 0; rw = 0; ramw = 0; hlt = 0;
        a = 0; b = 0; aop = 0; res = 0; imm = 0;
        case (st)
            0:  begin b = 2'b10; res = 2'b10; pcw = mr; irw = mr; end
            1:  begin a = 2'b10; b = 2'b01; imm = 3'b010; end
            2:  begin a = 2'b01; b = 2'b01; imm = o[5] ? 3'b001 : 3'b000; end
            3:  adr = 1;
            4:  begin res = 2'b01; rw = 1; end
            5:  begin adr = 1; ramw = 1; end
            6:  begin a = 2'b01; b = 2'b00; aop = 2'b10; end
            7:  begin a = 2'b01; b = 2'b01; aop = 2'b10; end
            8:  rw = 1;
            9:  begin a = 2'b01; aop = 2'b01; pcw = fl; end
            10: begin a = 2'b10; b = 2'b10; pcw = 1; end
            11: begin a = 2'b01; b = 2'b01; res = 2'b10; pcw = 1; end
            12: begin a = 2'b10; b = 2'b10; res = 2'b10; rw = 1; end
            13: begin b = 2'b01; imm = 3'b011; res = 2'b11; rw = 1; end
            14: hlt = 1;
            default: ;
        endcase
        return {pcw, irw, adr, a, b, aop, res, rw, ramw, imm, hlt};
    endfunction

    task automatic push_exp(input int st, input bit mr, input bit fl,
                            input logic [6:0] o, input int ir);
        exp_t e;
        e.idx  = n_push;
        e.st   = 4'(st);
        e.ctrl = exp_ctrl(st, mr, fl, o);
        e.ir   = 4'(ir);
        q.push_back(e);
        n_push++;
    endtask

    // One clock cycle: drive inputs just after the edge, queue what the DUT
    // should present during this cycle.
    task automatic step(input logic [6:0] o, input bit mr, input bit fl,
                        input int st, input int ir);
        @(posedge clk);
        #1;
        op = o; mem_ready = mr; flag = fl;
        push_exp(st, mr, fl, o, ir);
    endtask

    // Monitor: compares on every falling edge, or immediately on chk_now for
    // checks that must happen without a clock edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or chk_now);
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (state !== e.st) begin
                    bad++;
                    $display("FAIL state[%0d] got=%0d want=%0d", e.idx, state, e.st);
                end
                total++;
                if (act_ctrl !== e.ctrl) begin
                    bad++;
                    $display("FAIL ctrl[%0d] state=%0d got=%b want=%b", e.idx, state, act_ctrl, e.ctrl);
                end
                total++;
                if (instret !== e.ir) begin
                    bad++;
                    $display("FAIL instret[%0d] got=%0d want=%0d", e.idx, instret, e.ir);
                end
            end
        end
    end

    initial begin
        int waited;
        rst = 1'b1; op = '0; flag = 1'b0; mem_ready = 1'b0;
        #3;
        push_exp(0, 0, 0, '0, 0);
        -> chk_now;
        #5 rst = 1'b0;

        // R-type: 0,1,6,8 -> 0
        step(OP_R, 1, 0, 0, 0);
        step(OP_R, 1, 0, 1, 0);
        step(OP_R, 1, 0, 6, 0);
        step(OP_R, 1, 0, 8, 0);
        // load with two MEMREAD wait cycles
        step(OP_L, 1, 0, 0, 1);
        step(OP_L, 1, 0, 1, 1);
        step(OP_L, 0, 0, 2, 1);
        step(OP_L, 0, 0, 3, 1);
        step(OP_L, 0, 0, 3, 1);
        step(OP_L, 1, 0, 3, 1);
        step(OP_L, 0, 0, 4, 1);
        // branch not taken, then taken (flag toggled outside BRANCH too)
        step(OP_B, 1, 1, 0, 2);
        step(OP_B, 1, 1, 1, 2);
        step(OP_B, 1, 0, 9, 2);
        step(OP_B, 1, 0, 0, 3);
        step(OP_B, 1, 1, 1, 3);
        step(OP_B, 1, 1, 9, 3);
        // JALR then LUI
        step(OP_JR, 1, 0, 0, 4);
        step(OP_JR, 1, 0, 1, 4);
        step(OP_JR, 1, 0, 11, 4);
        step(OP_JR, 1, 0, 12, 4);
        step(OP_U, 1, 0, 0, 5);
        step(OP_U, 1, 0, 1, 5);
        step(OP_U, 0, 0, 13, 5);
        // JAL
        step(OP_J, 1, 0, 0, 6);
        step(OP_J, 1, 0, 1, 6);
        step(OP_J, 0, 0, 10, 6);
        step(OP_J, 0, 0, 8, 6);
        // I-type
        step(OP_I, 1, 0, 0, 7);
        step(OP_I, 1, 0, 1, 7);
        step(OP_I, 1, 0, 7, 7);
        step(OP_I, 1, 0, 8, 7);
        // store with one wait cycle
        step(OP_S, 1, 0, 0, 8);
        step(OP_S, 1, 0, 1, 8);
        step(OP_S, 1, 0, 2, 8);
        step(OP_S, 0, 0, 5, 8);
        step(OP_S, 1, 0, 5, 8);
        // eight LUIs walk the 4-bit counter through its wrap: 9..15,0 -> 1
        for (int i = 0; i < 8; i++) begin
            step(OP_U, 1, 0, 0, (9 + i) % 16);
            step(OP_U, 1, 0, 1, (9 + i) % 16);
            step(OP_U, 1, 0, 13, (9 + i) % 16);
        end
        // FETCH stall, then illegal opcode parks the FSM
        step(OP_X, 0, 0, 0, 1);
        step(OP_X, 1, 0, 0, 1);
        step(OP_X, 1, 0, 1, 1);
        for (int i = 0; i < 10; i++)
            step(OP_X, 1, 1, 14, 1);
        // synchronous-looking reset out of ILLEGAL
        @(posedge clk);
        #1;
        rst = 1'b1; mem_ready = 1'b0; flag = 1'b0;
        push_exp(0, 0, 0, OP_X, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_exp(0, 0, 0, OP_X, 0);
        // retire one LUI, then reset asynchronously in the middle of a stalled store
        step(OP_U, 1, 0, 0, 0);
        step(OP_U, 1, 0, 1, 0);
        step(OP_U, 1, 0, 13, 0);
        step(OP_S, 1, 0, 0, 1);
        step(OP_S, 1, 0, 1, 1);
        step(OP_S, 0, 0, 2, 1);
        step(OP_S, 0, 0, 5, 1);
        #6;
        rst = 1'b1;
        #1;
        push_exp(0, 0, 0, OP_S, 0);
        -> chk_now;
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_exp(0, 0, 0, OP_S, 0);

        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d pending want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
